// File: rtl/z80_mmu_intc.sv
// Z80 system controller: a paged memory mapper that drives the upper physical address lines,
// plus a masked, prioritised IM 2 interrupt controller for up to seven edge-triggered sources.
module z80_mmu_intc #(
  parameter int          PAGE_BITS    = 2,
  parameter int          PHYS_BITS    = 6,
  parameter int          IRQ_CHANNELS = 4,
  parameter logic [7:0]  MAP_BASE     = 8'hF0,
  parameter logic [7:0]  IRQ_BASE     = 8'hD0,
  parameter int          RAM_PAGE     = 32
) (
  input  logic                    clk,
  input  logic                    n_res,
  input  logic [15:0]             a,
  input  logic [7:0]              d_in,
  output logic [7:0]              d_out,
  output logic                    d_oe,
  input  logic                    n_mreq,
  input  logic                    n_iorq,
  input  logic                    n_rd,
  input  logic                    n_wr,
  input  logic                    n_m1,
  input  logic [IRQ_CHANNELS-1:0] irq_in,
  output logic [PHYS_BITS-1:0]    ext_a,
  output logic                    n_ramcs,
  output logic                    n_romcs,
  output logic                    n_int
);

  localparam int NBANK = 2 ** PAGE_BITS;

  logic [PHYS_BITS-1:0]    bank [NBANK];
  logic [IRQ_CHANNELS-1:0] pending, mask, irq_hist;
  logic [IRQ_CHANNELS-1:0] irq_rise, active, w1c_clr, ack_clr;
  logic [3:0]              vbase;
  logic [2:0]              chan_q, prio, chan_out;
  logic                    wr_prev, ack_prev, n_int_q;
  logic                    wr_cond, wr_commit, ack, ack_start, ack_end;
  logic                    map_cs, irq_cs;
  logic                    unused_bits;

  assign unused_bits = ^{a[15-PAGE_BITS:8], d_in};

  assign map_cs    = (a[7:PAGE_BITS] == MAP_BASE[7:PAGE_BITS]);
  assign irq_cs    = (a[7:2] == IRQ_BASE[7:2]);
  assign wr_cond   = ~n_iorq & ~n_wr & n_m1;
  assign wr_commit = wr_cond & ~wr_prev;
  assign ack       = ~n_iorq & ~n_m1;
  assign ack_start = ack & ~ack_prev;
  assign ack_end   = ~ack & ack_prev;

  assign active   = pending & mask;
  assign irq_rise = irq_in & ~irq_hist;
  assign w1c_clr  = (wr_commit && irq_cs && a[1:0] == 2'd0) ? d_in[IRQ_CHANNELS-1:0] : '0;

  // Lowest-index enabled pending channel wins; 7 means nothing to service.
  always_comb begin
    prio = 3'd7;
    for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
      if (active[i]) prio = 3'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < IRQ_CHANNELS; i++) begin
      ack_clr[i] = ack_end && (chan_q == 3'(i));
    end
  end

  // Bank registers; reset lays bank 0 over ROM and the rest over consecutive RAM pages.
  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      for (int i = 0; i < NBANK; i++) begin
        if (i == 0) bank[i] <= '0;
        else        bank[i] <= PHYS_BITS'(RAM_PAGE + i - 1);
      end
    end else if (wr_commit && map_cs) begin
      bank[a[PAGE_BITS-1:0]] <= d_in[PHYS_BITS-1:0];
    end
  end

  // Write and acknowledge strobes are edge-detected so wait states cannot repeat them.
  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      wr_prev  <= 1'b0;
      ack_prev <= 1'b0;
      irq_hist <= '0;
      pending  <= '0;
      mask     <= '0;
      vbase    <= '0;
      chan_q   <= 3'd7;
      n_int_q  <= 1'b1;
    end else begin
      wr_prev  <= wr_cond;
      ack_prev <= ack;
      irq_hist <= irq_in;
      pending  <= (pending & ~w1c_clr & ~ack_clr) | irq_rise;
      n_int_q  <= ~|active;
      if (ack_start) chan_q <= prio;
      if (wr_commit && irq_cs && a[1:0] == 2'd1) mask  <= d_in[IRQ_CHANNELS-1:0];
      if (wr_commit && irq_cs && a[1:0] == 2'd2) vbase <= d_in[7:4];
    end
  end

  // Before the latch edge the vector follows live priority; afterwards it is frozen.
  assign chan_out = ack_prev ? chan_q : prio;

  always_comb begin
    d_out = 8'h00;
    if (ack) begin
      d_out = {vbase, chan_out, 1'b0};
    end else if (map_cs) begin
      d_out = 8'(bank[a[PAGE_BITS-1:0]]);
    end else if (irq_cs) begin
      case (a[1:0])
        2'd0:    d_out = 8'(pending);
        2'd1:    d_out = 8'(mask);
        2'd2:    d_out = {vbase, 4'h0};
        default: d_out = {n_int_q, 3'b000, 1'b0, chan_q};
      endcase
    end
  end

  assign d_oe    = n_res & ((~n_iorq & ~n_rd & (map_cs | irq_cs)) | ack);
  assign ext_a   = bank[a[15:16-PAGE_BITS]];
  assign n_ramcs = n_mreq | ~ext_a[PHYS_BITS-1];
  assign n_romcs = n_mreq | ext_a[PHYS_BITS-1];
  assign n_int   = n_int_q;

endmodule

// File: tb/tb_z80_mmu_intc.sv
// Directed bench for z80_mmu_intc: bus cycles are driven and sampled on the falling clock edge.
module tb_z80_mmu_intc;

  logic        clk = 1'b0;
  logic        n_res;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        n_mreq, n_iorq, n_rd, n_wr, n_m1;
  logic [3:0]  irq_in;
  logic [5:0]  ext_a;
  logic        n_ramcs, n_romcs, n_int;

  int checks   = 0;
  int failures = 0;
  logic [7:0] rd_data;
  logic       rd_oe;

  z80_mmu_intc dut (
    .clk(clk), .n_res(n_res), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1),
    .irq_in(irq_in), .ext_a(ext_a), .n_ramcs(n_ramcs), .n_romcs(n_romcs), .n_int(n_int)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data, input int waits);
    @(negedge clk);
    a = {8'h00, port}; d_in = data; n_iorq = 1'b0; n_wr = 1'b0;
    tick(1 + waits);
    idle();
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data, output logic oe);
    @(negedge clk);
    a = {8'h00, port}; n_iorq = 1'b0; n_rd = 1'b0;
    #1;
    data = d_out; oe = d_oe;
    idle();
  endtask

  task automatic pulse_irq(input int ch);
    @(negedge clk);
    irq_in[ch] = 1'b1;
    @(negedge clk);
    irq_in[ch] = 1'b0;
  endtask

  task automatic start_ack();
    @(negedge clk);
    a = 16'h00FF; n_iorq = 1'b0; n_m1 = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    n_res = 1'b0; a = 16'h0000; d_in = 8'h00; irq_in = 4'h0;
    #12;
    check_output("reset_n_int", {7'b0, n_int}, 8'h01);
    check_output("reset_d_oe", {7'b0, d_oe}, 8'h00);
    @(negedge clk);
    n_res = 1'b1;

    io_read(8'hF0, rd_data, rd_oe); check_output("bank0_reset", rd_data, 8'h00);
    check_output("bank_read_oe", {7'b0, rd_oe}, 8'h01);
    io_read(8'hF1, rd_data, rd_oe); check_output("bank1_reset", rd_data, 8'h20);
    io_read(8'hF2, rd_data, rd_oe); check_output("bank2_reset", rd_data, 8'h21);
    io_read(8'hF3, rd_data, rd_oe); check_output("bank3_reset", rd_data, 8'h22);
    io_read(8'h50, rd_data, rd_oe); check_output("unselected_oe", {7'b0, rd_oe}, 8'h00);

    @(negedge clk);
    a = 16'h4000; n_mreq = 1'b0; #1;
    check_output("ram_ext_a", {2'b0, ext_a}, 8'h20);
    check_output("ram_n_ramcs", {7'b0, n_ramcs}, 8'h00);
    check_output("ram_n_romcs", {7'b0, n_romcs}, 8'h01);
    idle();

    io_write(8'hF2, 8'h15, 3);
    @(negedge clk);
    a = 16'h8123; n_mreq = 1'b0; #1;
    check_output("map_ext_a", {2'b0, ext_a}, 8'h15);
    check_output("map_n_romcs", {7'b0, n_romcs}, 8'h00);
    check_output("map_n_ramcs", {7'b0, n_ramcs}, 8'h01);
    idle();

    pulse_irq(0);
    io_read(8'hD0, rd_data, rd_oe); check_output("pend0_set", rd_data, 8'h01);
    io_write(8'hD0, 8'h01, 2);
    io_read(8'hD0, rd_data, rd_oe); check_output("w1c_clear", rd_data, 8'h00);

    pulse_irq(0);
    @(negedge clk);
    a = 16'h00D0; d_in = 8'h01; n_iorq = 1'b0; n_wr = 1'b0;
    tick(1);
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    tick(2);
    idle();
    io_read(8'hD0, rd_data, rd_oe); check_output("single_commit", rd_data, 8'h01);
    io_write(8'hD0, 8'h01, 0);

    io_write(8'hD1, 8'h0C, 0);
    io_write(8'hD2, 8'hA7, 0);
    io_read(8'hD2, rd_data, rd_oe); check_output("vbase_read", rd_data, 8'hA0);
    pulse_irq(3);
    pulse_irq(2);
    tick(2);
    check_output("prio_n_int", {7'b0, n_int}, 8'h00);
    io_read(8'hD0, rd_data, rd_oe); check_output("prio_pending", rd_data, 8'h0C);
    start_ack();
    check_output("ack1_vec_comb", d_out, 8'hA4);
    check_output("ack1_oe", {7'b0, d_oe}, 8'h01);
    tick(1);
    check_output("ack1_vec_latched", d_out, 8'hA4);
    idle();
    tick(2);
    io_read(8'hD0, rd_data, rd_oe); check_output("ack1_pending", rd_data, 8'h08);
    check_output("ack1_n_int", {7'b0, n_int}, 8'h00);
    start_ack();
    check_output("ack2_vec", d_out, 8'hA6);
    tick(1);
    idle();
    tick(3);
    check_output("ack2_n_int", {7'b0, n_int}, 8'h01);
    io_read(8'hD3, rd_data, rd_oe); check_output("status_read", rd_data, 8'h83);

    io_write(8'hD1, 8'h00, 0);
    pulse_irq(0);
    tick(2);
    start_ack();
    check_output("spurious_vec", d_out, 8'hAE);
    tick(1);
    idle();
    tick(3);
    io_read(8'hD0, rd_data, rd_oe); check_output("spurious_pending", rd_data, 8'h01);
    check_output("spurious_n_int", {7'b0, n_int}, 8'h01);
    io_write(8'hD0, 8'h01, 0);

    pulse_irq(1);
    tick(1);
    @(negedge clk);
    a = 16'h00D0; d_in = 8'h02; n_iorq = 1'b0; n_wr = 1'b0; irq_in[1] = 1'b1;
    tick(1);
    idle();
    irq_in[1] = 1'b0;
    io_read(8'hD0, rd_data, rd_oe); check_output("collision_set_wins", rd_data, 8'h02);
    io_write(8'hD0, 8'h02, 0);
    io_read(8'hD0, rd_data, rd_oe); check_output("collision_cleanup", rd_data, 8'h00);

    io_write(8'hD1, 8'h02, 0);
    pulse_irq(1);
    tick(2);
    check_output("rst_pre_n_int", {7'b0, n_int}, 8'h00);
    start_ack();
    tick(1);
    #2;
    n_res = 1'b0;
    #1;
    check_output("rst_mid_ack_oe", {7'b0, d_oe}, 8'h00);
    check_output("rst_mid_ack_n_int", {7'b0, n_int}, 8'h01);
    idle();
    @(negedge clk);
    n_res = 1'b1;
    io_read(8'hD0, rd_data, rd_oe); check_output("rst_pending", rd_data, 8'h00);
    io_read(8'hD1, rd_data, rd_oe); check_output("rst_mask", rd_data, 8'h00);
    io_read(8'hF2, rd_data, rd_oe); check_output("rst_bank2", rd_data, 8'h21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
